// File: rtl/rstseq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rstseq_pkg;

  typedef enum logic [2:0] {
    RS_ASSERT,
    RS_WAIT_LOCK,
    RS_HOLD,
    RS_RELEASE,
    RS_RUN
  } rs_state_e;

  localparam int unsigned RSTSEQ_CNT_SAT = 255;

  // Lock loss and button presses only count once the sequencer has left WAIT_LOCK.
  function automatic logic rs_event_armed(rs_state_e s);
    return s inside {RS_HOLD, RS_RELEASE, RS_RUN};
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Multi-stage flip-flop synchroniser with a configurable reset value.
module rst_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged multi-domain reset sequencer gated by PLL lock and a push-button.
// Define RSTSEQ_DEBOUNCE_EN to require DEBOUNCE_CYC stable-low samples per press.
module rst_sequencer
  import rstseq_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned HOLD_CYC     = 32,
  parameter int unsigned STAGE_CYC    = 16,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pll_locked,
  input  logic            ext_rst_n,
  output logic [N_CH-1:0] rst_out,
  output logic            all_released,
  output logic [7:0]      reset_count
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC) + 1;
  localparam int unsigned STAGE_W = $clog2(STAGE_CYC) + 1;

  rs_state_e          state_q;
  logic [N_CH-1:0]    rst_q;
  logic [N_CH-1:0]    rst_shift;
  logic               all_rel_q;
  logic [7:0]         cnt_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [STAGE_W-1:0] stage_q;

  logic lock_s;
  logic btn_s;
  logic press;
  logic rst_event;

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lock (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  rst_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_btn (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (ext_rst_n),
    .q_o    (btn_s)
  );

`ifdef RSTSEQ_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC) + 1;

  logic [DEB_W-1:0] deb_q;
  logic [DEB_W-1:0] deb_d;

  // Count saturates at DEBOUNCE_CYC so a long press fires exactly once.
  always_comb begin
    deb_d = deb_q;
    press = 1'b0;
    if (btn_s) begin
      deb_d = '0;
    end else if (deb_q != DEB_W'(DEBOUNCE_CYC)) begin
      deb_d = deb_q + DEB_W'(1);
      press = (deb_q == DEB_W'(DEBOUNCE_CYC - 1));
    end
    if (rst_event) begin
      deb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end
`else
  always_comb begin
    press = ~btn_s;
  end

  if (DEBOUNCE_CYC == 0) begin : g_debounce_unused
  end
`endif

  always_comb begin
    rst_event = rs_event_armed(state_q) && (!lock_s || press);
    rst_shift = rst_q << 1;
  end

  // WAIT_LOCK samples the synchroniser output, so HOLD begins at edge
  // 1+SYNC_STAGES and bit 0 falls exactly at edge 1+SYNC_STAGES+1+HOLD_CYC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RS_ASSERT;
      rst_q     <= '1;
      all_rel_q <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      stage_q   <= '0;
    end else if (rst_event) begin
      state_q   <= RS_ASSERT;
      rst_q     <= '1;
      all_rel_q <= 1'b0;
      hold_q    <= '0;
      stage_q   <= '0;
      if (cnt_q != 8'(RSTSEQ_CNT_SAT)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        RS_ASSERT: begin
          state_q   <= RS_WAIT_LOCK;
          rst_q     <= '1;
          all_rel_q <= 1'b0;
        end
        RS_WAIT_LOCK: begin
          if (lock_s && btn_s) begin
            state_q <= RS_HOLD;
            hold_q  <= HOLD_W'(HOLD_CYC);
          end
        end
        RS_HOLD: begin
          if (hold_q == '0) begin
            rst_q   <= rst_shift;
            stage_q <= '0;
            if (rst_shift == '0) begin
              state_q   <= RS_RUN;
              all_rel_q <= 1'b1;
            end else begin
              state_q <= RS_RELEASE;
            end
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        RS_RELEASE: begin
          if (stage_q == STAGE_W'(STAGE_CYC - 1)) begin
            stage_q <= '0;
            rst_q   <= rst_shift;
            if (rst_shift == '0) begin
              state_q   <= RS_RUN;
              all_rel_q <= 1'b1;
            end
          end else begin
            stage_q <= stage_q + STAGE_W'(1);
          end
        end
        RS_RUN: begin
          rst_q     <= '0;
          all_rel_q <= 1'b1;
        end
        default: begin
          state_q   <= RS_ASSERT;
          rst_q     <= '1;
          all_rel_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out      = rst_q;
  assign all_released = all_rel_q;
  assign reset_count  = cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected rst_out transitions (value, edge)
// are queued with each stimulus and matched against a negedge change monitor.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b1;
  logic       ext_rst_n = 1'b1;
  logic [3:0] rst_out;
  logic       all_released;
  logic [7:0] reset_count;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] rst;
    logic       allrel;
    int         at;
  } tr_t;

  tr_t exp_q[$];
  tr_t obs_q[$];
  logic [4:0] mon_prev = 5'b0_1111;

  rst_sequencer #(
    .N_CH         (4),
    .HOLD_CYC     (32),
    .STAGE_CYC    (16),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .ext_rst_n    (ext_rst_n),
    .rst_out      (rst_out),
    .all_released (all_released),
    .reset_count  (reset_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ({all_released, rst_out} !== mon_prev) begin
      obs_q.push_back('{rst_out, all_released, cyc});
      mon_prev = {all_released, rst_out};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<1000000", $time);
    $fatal(1);
  end

  // Queue the staged release: n transitions starting with bit 0 at edge rel0.
  task automatic push_seq(input int rel0, input int n);
    logic [3:0] all1;
    logic [3:0] v;
    all1 = 4'hF;
    for (int k = 0; k < n; k++) begin
      v = all1 << (k + 1);
      exp_q.push_back('{v, (v == 4'h0), rel0 + k * 16});
    end
  endtask

  task automatic push_event(input int at);
    exp_q.push_back('{4'hF, 1'b0, at});
  endtask

  task automatic next_obs(output tr_t ob, output bit got);
    got = 1'b0;
    ob  = '{4'hx, 1'bx, -1};
    for (int i = 0; i < 300; i++) begin
      if (obs_q.size() > 0) break;
      @(negedge clk);
    end
    if (obs_q.size() > 0) begin
      ob  = obs_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    pll_locked = 1'b1;
    ext_rst_n  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rst_out !== 4'hF) begin
      fails++; $display("FAIL reset_rst_out: got %b required 1111", rst_out);
    end
    checks++;
    if (all_released !== 1'b0) begin
      fails++; $display("FAIL reset_all_released: got %b required 0", all_released);
    end
    checks++;
    if (reset_count !== 8'd0) begin
      fails++; $display("FAIL reset_count: got %0d required 0", reset_count);
    end
    obs_q.delete();
  endtask

  task automatic test_power_up;
    tr_t ex, ob;
    bit  got;
    int  base;
    @(negedge clk);
    reset_n = 1'b1;
    base = cyc;
    push_seq(base + 36, 4);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL power_up_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - base, ex.rst, ex.allrel, ex.at - base);
      end
    end
    checks++;
    if (reset_count !== 8'd0) begin
      fails++; $display("FAIL power_up_count: got %0d required 0", reset_count);
    end
  endtask

  task automatic test_lock_loss_run;
    tr_t ex, ob;
    bit  got;
    int  c0;
    @(negedge clk);
    pll_locked = 1'b0;
    c0 = cyc;
    push_event(c0 + 3);
    push_seq(c0 + 39, 4);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL lock_loss_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - c0, ex.rst, ex.allrel, ex.at - c0);
      end
    end
    checks++;
    if (reset_count !== 8'd1) begin
      fails++; $display("FAIL lock_loss_count: got %0d required 1", reset_count);
    end
  endtask

`ifdef RSTSEQ_DEBOUNCE_EN
  task automatic test_button;
    tr_t ex, ob;
    bit  got;
    int  c0;
    @(negedge clk);
    ext_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    ext_rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL debounce_glitch: got %0d rst_out changes required 0", obs_q.size());
    end
    checks++;
    if (reset_count !== 8'd1) begin
      fails++; $display("FAIL debounce_glitch_count: got %0d required 1", reset_count);
    end
    obs_q.delete();
    @(negedge clk);
    ext_rst_n = 1'b0;
    c0 = cyc;
    push_event(c0 + 10);
    push_seq(c0 + 56, 4);
    repeat (20) @(negedge clk);
    ext_rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL debounce_press_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - c0, ex.rst, ex.allrel, ex.at - c0);
      end
    end
    checks++;
    if (reset_count !== 8'd2) begin
      fails++; $display("FAIL debounce_press_count: got %0d required 2", reset_count);
    end
  endtask
`else
  task automatic test_button;
    tr_t ex, ob;
    bit  got;
    int  c0;
    @(negedge clk);
    ext_rst_n = 1'b0;
    c0 = cyc;
    push_event(c0 + 3);
    push_seq(c0 + 96, 4);
    repeat (60) @(negedge clk);
    ext_rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL button_held_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - c0, ex.rst, ex.allrel, ex.at - c0);
      end
    end
    checks++;
    if (reset_count !== 8'd2) begin
      fails++; $display("FAIL button_count: got %0d required 2", reset_count);
    end
  endtask
`endif

  task automatic test_release_abort;
    tr_t ex, ob;
    bit  got;
    int  c0;
    int  k;
    @(negedge clk);
    pll_locked = 1'b0;
    c0 = cyc;
    push_event(c0 + 3);
    push_seq(c0 + 39, 2);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL abort_lead_in: got rst_out=%b at edge %0d, required %b at edge %0d",
                 ob.rst, ob.at - c0, ex.rst, ex.at - c0);
      end
    end
    @(negedge clk);
    pll_locked = 1'b0;
    ext_rst_n  = 1'b0;
    k = cyc;
    push_event(k + 3);
    push_seq(k + 39, 4);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    ext_rst_n  = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL abort_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - k, ex.rst, ex.allrel, ex.at - k);
      end
    end
    checks++;
    if (reset_count !== 8'd4) begin
      fails++; $display("FAIL abort_count: got %0d required 4", reset_count);
    end
  endtask

  task automatic test_saturation;
    tr_t ex, ob;
    bit  got;
    int  c;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pll_locked = 1'b0;
      c = cyc;
      if (i == 0) push_event(c + 3);
      repeat (3) @(negedge clk);
      pll_locked = 1'b1;
      repeat (6) @(negedge clk);
      if (i == 99) begin
        checks++;
        if (reset_count !== 8'd104) begin
          fails++; $display("FAIL sat_midway_count: got %0d required 104", reset_count);
        end
      end
    end
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel) begin
        fails++;
        $display("FAIL sat_first_event: got rst_out=%b all_released=%b required %b/%b",
                 ob.rst, ob.allrel, ex.rst, ex.allrel);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL sat_no_release: got %0d rst_out changes required 0", obs_q.size());
    end
    checks++;
    if (reset_count !== 8'd255) begin
      fails++; $display("FAIL sat_count: got %0d required 255", reset_count);
    end
  endtask

  task automatic test_async_reset;
    tr_t ex, ob;
    bit  got;
    int  base;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (reset_count !== 8'd0 || rst_out !== 4'hF || all_released !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_hold: got count=%0d rst_out=%b all_released=%b required 0/1111/0",
               reset_count, rst_out, all_released);
    end
    repeat (2) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    base = cyc;
    push_seq(base + 36, 2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.at != ex.at) begin
        fails++;
        $display("FAIL async_restart_seq: got rst_out=%b at edge %0d, required %b at edge %0d",
                 ob.rst, ob.at - base, ex.rst, ex.at - base);
      end
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 4'hF || all_released !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_release: got rst_out=%b all_released=%b required 1111/0",
               rst_out, all_released);
    end
    repeat (2) @(negedge clk);
    obs_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    base = cyc;
    push_seq(base + 36, 4);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      next_obs(ob, got);
      checks++;
      if (!got || ob.rst !== ex.rst || ob.allrel !== ex.allrel || ob.at != ex.at) begin
        fails++;
        $display("FAIL async_full_seq: got rst_out=%b all_released=%b at edge %0d, required %b/%b at edge %0d",
                 ob.rst, ob.allrel, ob.at - base, ex.rst, ex.allrel, ex.at - base);
      end
    end
    checks++;
    if (reset_count !== 8'd0) begin
      fails++; $display("FAIL async_final_count: got %0d required 0", reset_count);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss_run();
    test_button();
    test_release_abort();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
